mul_issue_ctrl: RTL and testbench

Handshake front-end for the 8x8 signed radix-2 Booth multiplier. Accepts operand pairs on a valid/ready interface, latches them and holds them stable on the multiplier's operand buses, and issues a one-cycle start pulse. It then waits for the multiplier's completion edge, captures the 16-bit product and presents it downstream on a valid/ready result interface. Also provides a zero-operand bypass and a watchdog timeout; it sits directly upstream of the multiplier and owns its `bgn` input.

---
 rtl/mul_issue_ctrl.sv | 113 +++++++++++
 tb/tb_mul_issue_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// Issue controller for the 8x8 signed Booth multiplier: accepts operand pairs, pulses
// mul_bgn, waits for the mul_stop rising edge (or a watchdog expiry) and returns the product.
module mul_issue_ctrl #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic [3:0]  in_tag,
  output logic        mul_bgn,
  output logic [7:0]  mul_ibusa,
  output logic [7:0]  mul_ibusb,
  input  logic        mul_stop,
  input  logic [15:0] mul_obus,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_prod,
  output logic [3:0]  out_tag,
  output logic        out_err,
  output logic        busy,
  output logic [1:0]  fsm_state
);

  // Handshake rule for both ports: a transfer happens on a rising edge where valid and
  // ready are both high; once raised, out_valid and its payload hold until that edge.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYC - 1);

  state_t     state;
  logic       stop_d;
  logic [7:0] wdog;
  logic       stop_rise;

  // Only a fresh edge counts, so a stop level left high by a previous run is ignored.
  assign stop_rise = mul_stop & ~stop_d;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= S_IDLE;
      stop_d    <= 1'b0;
      wdog      <= 8'd0;
      mul_bgn   <= 1'b0;
      mul_ibusa <= 8'h00;
      mul_ibusb <= 8'h00;
      out_valid <= 1'b0;
      out_prod  <= 16'h0000;
      out_tag   <= 4'h0;
      out_err   <= 1'b0;
    end else begin
      stop_d <= mul_stop;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mul_ibusa <= in_a;
            mul_ibusb <= in_b;
            out_tag   <= in_tag;
            if (in_a == 8'h00 || in_b == 8'h00) begin
              out_prod  <= 16'h0000;
              out_err   <= 1'b0;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              mul_bgn <= 1'b1;
              state   <= S_START;
            end
          end
        end
        S_START: begin
          mul_bgn <= 1'b0;
          wdog    <= 8'd0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          wdog <= wdog + 8'd1;
          // Completion has priority over a watchdog expiry in the same cycle.
          if (stop_rise) begin
            out_prod  <= mul_obus;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else if (wdog == WDOG_LAST) begin
            out_prod  <= 16'h0000;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: directed operand pairs, a behavioural multiplier responder
// and a scoreboard monitor that checks every result handshake.
module tb_mul_issue_ctrl;

  logic        clk;
  logic        rst_b;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [3:0]  in_tag;
  logic        mul_bgn;
  logic [7:0]  mul_ibusa;
  logic [7:0]  mul_ibusb;
  logic        mul_stop;
  logic [15:0] mul_obus;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_prod;
  logic [3:0]  out_tag;
  logic        out_err;
  logic        busy;
  logic [1:0]  fsm_state;

  int n_tests = 0;
  int n_fail  = 0;
  int bgn_cnt = 0;
  int stab_bad = 0;
  logic [7:0] cur_a = 8'h00;
  logic [7:0] cur_b = 8'h00;
  bit resp_en = 1'b1;
  int resp_lat = 3;
  logic [20:0] exp_q[$];

  mul_issue_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .mul_bgn(mul_bgn),
    .mul_ibusa(mul_ibusa), .mul_ibusb(mul_ibusb), .mul_stop(mul_stop),
    .mul_obus(mul_obus), .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_tag(out_tag), .out_err(out_err), .busy(busy),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural multiplier: product appears with a rising mul_stop resp_lat cycles after bgn.
  initial begin
    logic signed [15:0] prod;
    forever begin
      @(negedge clk);
      if (resp_en && mul_bgn && rst_b) begin
        prod = $signed(mul_ibusa) * $signed(mul_ibusb);
        repeat (resp_lat) @(posedge clk);
        #1;
        mul_obus = prod;
        mul_stop = 1'b1;
        @(posedge clk);
        #1;
        mul_stop = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mul_bgn) bgn_cnt++;
    if (busy && (mul_ibusa !== cur_a || mul_ibusb !== cur_b)) stab_bad++;
    if (rst_b && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL result: got prod=0x%0h tag=%0d err=%0b, expected nothing", out_prod, out_tag, out_err);
      end else begin
        check("result{prod,tag,err}", {11'd0, out_prod, out_tag, out_err}, {11'd0, exp_q.pop_front()});
      end
    end
  end

  // Driver: one full operation with timing, pulse-count and backpressure checks.
  task automatic do_op(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] tag, input logic [15:0] ep, input logic eerr,
                       input int ecyc, input int ebgn, input int hold);
    int n;
    int b0;
    int bad;
    bit seen;
    logic [20:0] held;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, " idle_before"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_a = a;
    in_b = b;
    in_tag = tag;
    cur_a = a;
    cur_b = b;
    exp_q.push_back({ep, tag, eerr});
    b0 = bgn_cnt;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 8'($urandom_range(0, 255));
    in_b = 8'($urandom_range(0, 255));
    in_tag = 4'($urandom_range(0, 15));
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      seen = out_valid;
    end
    check({name, " out_valid_cycle"}, 32'(n), 32'(ecyc));
    if (hold > 0) begin
      held = {out_prod, out_tag, out_err};
      bad = 0;
      repeat (hold) begin
        @(negedge clk);
        if ({out_prod, out_tag, out_err} !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      end
      check({name, " hold_stable"}, 32'(bad), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    check({name, " busy_after"}, 32'(busy), 32'd0);
    check({name, " in_ready_after"}, 32'(in_ready), 32'd1);
    check({name, " bgn_pulses"}, 32'(bgn_cnt - b0), 32'(ebgn));
    check({name, " operand_stable"}, 32'(stab_bad), 32'd0);
  endtask

  initial begin
    rst_b = 1'b0;
    in_valid = 1'b0;
    in_a = 8'h00;
    in_b = 8'h00;
    in_tag = 4'h0;
    mul_stop = 1'b0;
    mul_obus = 16'h0000;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst mul_bgn", 32'(mul_bgn), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_err", 32'(out_err), 32'd0);
    check("rst buses", {16'd0, mul_ibusa, mul_ibusb}, 32'd0);
    check("rst prod_tag", {12'd0, out_prod, out_tag}, 32'd0);
    rst_b = 1'b1;

    // Normal and signed-corner operations, latency 3 -> out_valid in cycle 5
    do_op("mul_7x6",   8'h07, 8'h06, 4'd3, 16'h002A, 1'b0, 5, 1, 0);
    do_op("mul_80x80", 8'h80, 8'h80, 4'd1, 16'h4000, 1'b0, 5, 1, 0);
    do_op("mul_FFx01", 8'hFF, 8'h01, 4'd2, 16'hFFFF, 1'b0, 5, 1, 0);
    do_op("mul_7Fx80", 8'h7F, 8'h80, 4'd4, 16'hC080, 1'b0, 5, 1, 0);
    do_op("mul_FFxFF", 8'hFF, 8'hFF, 4'd6, 16'h0001, 1'b0, 5, 1, 0);
    resp_lat = 1;
    do_op("mul_lat1",  8'h0A, 8'hF1, 4'd11, 16'hFF6A, 1'b0, 3, 1, 0);
    resp_lat = 3;

    // Zero bypass
    do_op("zero_a", 8'h00, 8'h5A, 4'd5, 16'h0000, 1'b0, 1, 0, 0);
    do_op("zero_b", 8'h33, 8'h00, 4'd12, 16'h0000, 1'b0, 1, 0, 0);

    // Stale stop level held high: watchdog expiry after 16 WAIT cycles
    @(posedge clk);
    #1;
    resp_en = 1'b0;
    mul_stop = 1'b1;
    repeat (2) @(posedge clk);
    do_op("timeout", 8'h03, 8'h05, 4'd7, 16'h0000, 1'b1, 18, 1, 0);
    @(posedge clk);
    #1;
    mul_stop = 1'b0;
    resp_en = 1'b1;
    @(posedge clk);

    // Backpressure for 10 cycles in DONE
    do_op("backpressure", 8'hF6, 8'h0C, 4'd8, 16'hFF88, 1'b0, 5, 1, 10);

    // Asynchronous reset in the middle of WAIT
    resp_en = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a = 8'h11;
    in_b = 8'h22;
    in_tag = 4'hA;
    cur_a = 8'h11;
    cur_b = 8'h22;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midwait state", 32'(fsm_state), 32'd2);
    #2;
    rst_b = 1'b0;
    #1;
    check("arst in_ready", 32'(in_ready), 32'd1);
    check("arst busy", 32'(busy), 32'd0);
    check("arst bgn_valid_err", {29'd0, mul_bgn, out_valid, out_err}, 32'd0);
    check("arst buses", {16'd0, mul_ibusa, mul_ibusb}, 32'd0);
    check("arst prod_tag", {12'd0, out_prod, out_tag}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    resp_en = 1'b1;
    do_op("after_reset", 8'h05, 8'h05, 4'd9, 16'h0019, 1'b0, 5, 1, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
